// File: rtl/wb_pkg.sv
// Shared writeback definitions: source numbering and the result payload carried by each source.
package wb_pkg;

  localparam int unsigned NUM_WB_REQ = 3;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: grants the first request at or after the pointer, then moves the
// pointer just past the winner. The grant is only issued while en is high.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    logic            found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IdxW'(cand);
      if (en && !found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|grant) begin
      ptr_d = (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among the writeback sources; the winning result is
// registered onto rf_write_*, which also serves as decode's bypass source for the write in flight.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_WB_REQ,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RA_W    = 5,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][RA_W-1:0]  req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_write_en,
  output logic [RA_W-1:0]               rf_write_addr,
  output logic [XLEN-1:0]               rf_write_data,
  output logic [IdxW-1:0]               wb_grant_idx
);

  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]    grant_idx;
  logic [RA_W-1:0]    sel_rd;
  logic [XLEN-1:0]    sel_data;

  logic            wr_en_q, wr_en_d;
  logic [RA_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [IdxW-1:0] idx_q, idx_d;

  // Gating with rst_n drops any handshake that coincides with reset.
  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (rst_n & ~wb_hold),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i];
        sel_data = req_data[i];
      end
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    idx_d     = idx_q;
    if (|grant) begin
      // x0 results still consume the slot but never write.
      wr_en_d   = (sel_rd != '0);
      wr_addr_d = sel_rd;
      wr_data_d = sel_data;
      idx_d     = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      idx_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      idx_q     <= idx_d;
    end
  end

  assign rf_write_en   = wr_en_q;
  assign rf_write_addr = wr_addr_q;
  assign rf_write_data = wr_data_q;
  assign wb_grant_idx  = idx_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: expected grants come from per-scenario tables, expected
// write-port contents are queued when stimulus is driven and compared one cycle later.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  idx;
  } out_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wb_hold;
  logic [2:0]       req_valid;
  logic [2:0][4:0]  req_rd;
  logic [2:0][31:0] req_data;
  logic [2:0]       req_ready;
  logic             rf_write_en;
  logic [4:0]       rf_write_addr;
  logic [31:0]      rf_write_data;
  logic [1:0]       wb_grant_idx;

  int   n_tot = 0;
  int   n_bad = 0;
  out_t sb[$];
  out_t act;
  out_t exp_o;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  logic [1:0]  last_idx;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .NUM_REQ (3),
    .XLEN    (32),
    .RA_W    (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_hold       (wb_hold),
    .req_valid     (req_valid),
    .req_rd        (req_rd),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .wb_grant_idx  (wb_grant_idx)
  );

  assign act = {rf_write_en, rf_write_addr, rf_write_data, wb_grant_idx};

  // Expected write-port contents one cycle after a given (bench-chosen) grant.
  function automatic void push_exp(input logic [2:0] g, input logic rstn);
    out_t e;
    int   k;
    if (!rstn) begin
      last_addr = '0;
      last_data = '0;
      last_idx  = '0;
      e = '0;
    end else if (g == 3'b000) begin
      e = {1'b0, last_addr, last_data, last_idx};
    end else begin
      k = g[0] ? 0 : (g[1] ? 1 : 2);
      last_addr = req_rd[k];
      last_data = req_data[k];
      last_idx  = 2'(k);
      e = {(last_addr != 5'd0), last_addr, last_data, last_idx};
    end
    sb.push_back(e);
  endfunction

  task automatic drive(input logic [2:0] v, input logic h, input logic r);
    req_valid = v;
    wb_hold   = h;
    rst_n     = r;
  endtask

  task automatic do_reset();
    drive(3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    last_addr = '0;
    last_data = '0;
    last_idx  = '0;
  endtask

  task automatic test_reset();
    req_rd   = {5'd3, 5'd2, 5'd1};
    req_data = {32'h33, 32'h22, 32'h11};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(3'b111, 1'b0, 1'b0);
      #1;
      n_tot++;
      if (req_ready !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_ready[%0d]: got %b want 000", i, req_ready);
      end
      push_exp(3'b000, 1'b0);
      @(negedge clk);
      exp_o = sb.pop_front();
      n_tot++;
      if (act !== exp_o) begin
        n_bad++;
        $display("FAIL reset_out[%0d]: got %h want %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] v[3]   = '{3'b001, 3'b000, 3'b000};
    logic [2:0] exp[3] = '{3'b001, 3'b000, 3'b000};
    req_rd[0]   = 5'd5;
    req_data[0] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      drive(v[i], 1'b0, 1'b1);
      #1;
      n_tot++;
      if (req_ready !== exp[i]) begin
        n_bad++;
        $display("FAIL single_ready[%0d]: got %b want %b", i, req_ready, exp[i]);
      end
      push_exp(exp[i], 1'b1);
      @(negedge clk);
      exp_o = sb.pop_front();
      n_tot++;
      if (act !== exp_o) begin
        n_bad++;
        $display("FAIL single_out[%0d]: got %h want %h", i, act, exp_o);
      end
      if (i == 0) begin
        n_tot++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd5 || rf_write_data !== 32'hDEADBEEF
            || wb_grant_idx !== WB_ALU) begin
          n_bad++;
          $display("FAIL single_write: got en=%b addr=%0d data=%h idx=%0d want 1/5/deadbeef/0",
                   rf_write_en, rf_write_addr, rf_write_data, wb_grant_idx);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    do_reset();
    req_rd   = {5'd3, 5'd2, 5'd1};
    req_data = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 1'b0, 1'b1);
      e = 3'b001 << (i % 3);
      #1;
      n_tot++;
      if (req_ready !== e) begin
        n_bad++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", i, req_ready, e);
      end
      push_exp(e, 1'b1);
      @(negedge clk);
      exp_o = sb.pop_front();
      n_tot++;
      if (act !== exp_o || rf_write_en !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_out[%0d]: got %h want %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [2:0] v[3]   = '{3'b010, 3'b111, 3'b011};
    logic [2:0] exp[3] = '{3'b010, 3'b100, 3'b001};
    req_rd   = {5'd4, 5'd0, 5'd9};
    req_data = {32'h4444, 32'h1234, 32'h9999};
    for (int i = 0; i < 3; i++) begin
      drive(v[i], 1'b0, 1'b1);
      #1;
      n_tot++;
      if (req_ready !== exp[i]) begin
        n_bad++;
        $display("FAIL zero_ready[%0d]: got %b want %b", i, req_ready, exp[i]);
      end
      push_exp(exp[i], 1'b1);
      @(negedge clk);
      exp_o = sb.pop_front();
      n_tot++;
      if (act !== exp_o) begin
        n_bad++;
        $display("FAIL zero_out[%0d]: got %h want %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_hold();
    logic       h[5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp[5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
    do_reset();
    req_rd   = {5'd13, 5'd12, 5'd11};
    req_data = {32'h0D, 32'h0C, 32'h0B};
    for (int i = 0; i < 5; i++) begin
      drive(3'b111, h[i], 1'b1);
      #1;
      n_tot++;
      if (req_ready !== exp[i]) begin
        n_bad++;
        $display("FAIL hold_ready[%0d]: got %b want %b", i, req_ready, exp[i]);
      end
      push_exp(exp[i], 1'b1);
      @(negedge clk);
      exp_o = sb.pop_front();
      n_tot++;
      if (act !== exp_o) begin
        n_bad++;
        $display("FAIL hold_out[%0d]: got %h want %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] v[3]   = '{3'b100, 3'b010, 3'b111};
    logic [2:0] exp[3] = '{3'b100, 3'b010, 3'b100};
    req_rd   = {5'd22, 5'd21, 5'd20};
    req_data = {32'h2222, 32'h2121, 32'h2020};
    for (int i = 0; i < 3; i++) begin
      drive(v[i], 1'b0, 1'b1);
      #1;
      n_tot++;
      if (req_ready !== exp[i]) begin
        n_bad++;
        $display("FAIL wrap_ready[%0d]: got %b want %b", i, req_ready, exp[i]);
      end
      push_exp(exp[i], 1'b1);
      @(negedge clk);
      exp_o = sb.pop_front();
      n_tot++;
      if (act !== exp_o) begin
        n_bad++;
        $display("FAIL wrap_out[%0d]: got %h want %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] v[3]   = '{3'b001, 3'b000, 3'b111};
    logic       r[3]   = '{1'b0, 1'b1, 1'b1};
    logic [2:0] exp[3] = '{3'b000, 3'b000, 3'b001};
    req_rd   = {5'd2, 5'd1, 5'd7};
    req_data = {32'hF2, 32'hF1, 32'h7777_7777};
    for (int i = 0; i < 3; i++) begin
      drive(v[i], 1'b0, r[i]);
      #1;
      n_tot++;
      if (req_ready !== exp[i]) begin
        n_bad++;
        $display("FAIL rstmid_ready[%0d]: got %b want %b", i, req_ready, exp[i]);
      end
      push_exp(exp[i], r[i]);
      @(negedge clk);
      exp_o = sb.pop_front();
      n_tot++;
      if (act !== exp_o) begin
        n_bad++;
        $display("FAIL rstmid_out[%0d]: got %h want %h", i, act, exp_o);
      end
    end
  endtask

  initial begin
    drive(3'b000, 1'b0, 1'b0);
    req_rd   = '0;
    req_data = '0;
    last_addr = '0;
    last_data = '0;
    last_idx  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_reg();
    test_hold();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter sharing the register file's single write port among the execution units that produce results (ALU, load/store unit, mul/div unit). Each source presents a result through a valid/ready handshake. One result is granted per cycle and registered onto the register-file write port. The registered write port also serves as the decode stage's bypass source for the write currently in flight.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback sources (index 0 = ALU, 1 = LSU, 2 = MDU)
- XLEN, 32, data width
- RA_W, 5, register address width

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- wb_hold  input  1  when high, no grant is issued this cycle
- req_valid  input  [NUM_REQ]  source i has a result
- req_rd  input  [NUM_REQ][RA_W]  destination register of source i
- req_data  input  [NUM_REQ][XLEN]  result of source i
- req_ready  output  [NUM_REQ]  one-hot (or zero) grant; result i accepted this cycle
- rf_write_en  output  1  register-file write enable
- rf_write_addr  output  RA_W  register-file write address
- rf_write_data  output  XLEN  register-file write data
- wb_grant_idx  output  $clog2(NUM_REQ)  source of the write currently on the rf_write_* outputs (debug/trace)

## Operation
- State:
  - round-robin pointer `ptr` (0..NUM_REQ-1)
  - output registers rf_write_en, rf_write_addr, rf_write_data, wb_grant_idx
- Grant (combinational):
  - If wb_hold=0 and any req_valid is high, grant the first valid source searching ptr, ptr+1, … with wrap-around modulo NUM_REQ.
  - req_ready is high only for that source.
  - req_ready depends combinationally on req_valid. Sources must not derive req_valid from req_ready.
- Source obligation: req_valid, req_rd and req_data are held stable until req_ready. A handshake occurs when req_valid & req_ready.
- Pointer update: on a handshake from source g, ptr <= (g+1) mod NUM_REQ. With no handshake, ptr is unchanged.
- Output register:
  - On a handshake from source g: rf_write_addr <= req_rd[g], rf_write_data <= req_data[g], wb_grant_idx <= g.
  - On that same handshake, rf_write_en <= 1 if req_rd[g] != 0. If req_rd[g] == 0 the result is consumed but no write occurs; rf_write_en <= 0.
  - With no handshake, rf_write_en <= 0. Addr, data and idx keep their previous values.
- wb_hold=1: req_ready is all zero and the next cycle's rf_write_en is 0. Requests stay pending and ptr is unchanged.
- Fairness: a continuously valid source is granted within NUM_REQ cycles of wb_hold being low.
- Reset (rst_n=0 at a clk edge): ptr=0, rf_write_en=0, rf_write_addr=0, rf_write_data=0, wb_grant_idx=0.
  - While rst_n=0, req_ready is forced to 0.
  - A handshake in progress when reset is asserted is discarded. No write reaches the register file.

## Timing
- Latency: a handshake in cycle N appears on rf_write_* in cycle N+1. The register file commits it at the N+2 edge and reads return it from cycle N+2.
- Bypass window: the decode stage compares its sources against rf_write_addr when rf_write_en=1 during cycle N+1.
- Throughput: one write per cycle, sustained, with no bubbles when requests are back-to-back.
- Simultaneous requests: exactly one grant per cycle. The others wait with req_ready low.
- Zero-register writes consume a slot and produce a cycle with rf_write_en=0.

## Structure
- Shared package `wb_pkg`:
  - NUM_WB_REQ=3
  - enum `wb_src_e` {WB_ALU=0, WB_LSU=1, WB_MDU=2}
  - struct `wb_req_t` {logic [4:0] rd; logic [31:0] data;}
- Sub-module `rr_arbiter` (parameter N): inputs req[N] and en; outputs grant[N] and grant_idx; owns the pointer.
  - Reused later for the memory-port arbiter.
- The top level holds the muxing and the output register.

## Test plan
- Single request: after reset, ALU valid with rd=5, data=0xDEADBEEF.
  - Required: req_ready[0]=1 the same cycle; next cycle rf_write_en=1, addr=5, data=0xDEADBEEF, wb_grant_idx=0; following cycle rf_write_en=0.
- Three sources continuously valid with rd=1/2/3:
  - Grants 0,1,2,0,1,2 on consecutive cycles, with rf_write_en=1 every cycle after the first.
- Zero register: LSU valid with rd=0, data=0x1234.
  - Required: req_ready[1]=1; next cycle rf_write_en=0; ptr advances to 2.
- Hold: all sources valid with wb_hold=1 for 3 cycles.
  - Required: req_ready=0 and rf_write_en=0 throughout, ptr stays 0; after release, source 0 is granted first.
- Wrap-around: after a grant to source 2, only source 1 is valid.
  - Required: source 1 is granted (search 0→1); ptr becomes 2.
- Reset mid-operation: rst_n low in the cycle of a handshake with rd=7.
  - Required: next cycle all outputs are 0 and no write to x7 occurs.
